// File: rtl/afpm_pkg.sv
// -----------------------------------------------------------------------------
// afpm_pkg
// Shared definitions for the logarithmic approximate FP16 multiplier front-end:
//   - FP16 field widths and the all-ones exponent value
//   - 2-bit operand class codes produced by the optional classifier
//   - state encoding of the operand loader handshake FSM
// -----------------------------------------------------------------------------
package afpm_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;  // zero or subnormal (exp == 0)
    localparam logic [1:0] CLS_INF    = 2'b10;
    localparam logic [1:0] CLS_NAN    = 2'b11;

    // COLLECT: output slot empty; HOLD: slot full; HOLD_PEND: slot full plus a
    // second complete pair parked in the assembly registers.
    typedef enum logic [1:0] {
        ST_COLLECT   = 2'b00,
        ST_HOLD      = 2'b01,
        ST_HOLD_PEND = 2'b10
    } loader_state_t;

endpackage : afpm_pkg

// File: rtl/afpm_operand_loader_if.sv
// -----------------------------------------------------------------------------
// afpm_operand_loader_if
// Byte-pad input side and operand-pair output side of the operand loader.
//   byte_a_in/byte_b_in/byte_valid : one byte of each operand per strobe
//   op_a/op_b/op_valid/op_ready    : assembled pair, valid/ready handshake
// Modports: slave  = the loader itself
//           master = the pads plus the multiplier core (driver of strobes/ready)
// -----------------------------------------------------------------------------
interface afpm_operand_loader_if #(
    parameter int OP_W   = 16,
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] byte_a_in;
    logic [BYTE_W-1:0] byte_b_in;
    logic              byte_valid;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              op_valid;
    logic              op_ready;

    modport slave (
        input  byte_a_in, byte_b_in, byte_valid, op_ready,
        output op_a, op_b, op_valid
    );

    modport master (
        output byte_a_in, byte_b_in, byte_valid, op_ready,
        input  op_a, op_b, op_valid
    );
endinterface : afpm_operand_loader_if

// File: rtl/afpm_fp16_classify.sv
// -----------------------------------------------------------------------------
// afpm_fp16_classify
// Combinational FP16 class decoder (only built with AFPM_LOADER_CLASSIFY_EN).
//   value : FP16 operand
//   cls   : 00 normal, 01 zero/subnormal, 10 inf, 11 NaN
// The whole module sits under the macro so the default build carries no
// unreferenced module.
// -----------------------------------------------------------------------------
`ifdef AFPM_LOADER_CLASSIFY_EN
module afpm_fp16_classify
    import afpm_pkg::*;
(
    input  logic [FP16_W-1:0] value,
    output logic [1:0]        cls
);
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign exp_s = value[MAN_W +: EXP_W];
    assign man_s = value[MAN_W-1:0];

    // Decode exponent/mantissa into the class code.
    always_comb begin
        cls = CLS_NORMAL;
        if (exp_s == {EXP_W{1'b0}}) begin
            cls = CLS_ZERO;
        end else if (exp_s == EXP_MAX) begin
            if (man_s == {MAN_W{1'b0}}) begin
                cls = CLS_INF;
            end else begin
                cls = CLS_NAN;
            end
        end else begin
            cls = CLS_NORMAL;
        end
    end
endmodule : afpm_fp16_classify
`endif

// File: rtl/afpm_operand_loader.sv
// -----------------------------------------------------------------------------
// afpm_operand_loader
// Rebuilds two OP_W-bit operands from BYTE_W-wide pad strobes (little-endian,
// low byte first), buffers one complete pair behind the output slot and hands
// pairs to the multiplier core over valid/ready.
// Ports:
//   clk, rst (async, active-high), ena (freezes all state when low)
//   bus     : afpm_operand_loader_if.slave (byte strobes in, operand pair out)
//   busy    : partial assembly in progress
//   overrun : sticky, a byte was dropped while a pair was pending
//   resync  : one-cycle pulse when the idle timeout discards a partial word
//   a_cls, b_cls : FP16 class of op_a/op_b, only with AFPM_LOADER_CLASSIFY_EN
// Parameters: OP_W, BYTE_W, TIMEOUT_CYC (0 disables the idle timeout).
// -----------------------------------------------------------------------------
module afpm_operand_loader
    import afpm_pkg::*;
#(
    parameter int OP_W        = 16,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    afpm_operand_loader_if.slave     bus,
    output logic                     busy,
    output logic                     overrun,
    output logic                     resync
`ifdef AFPM_LOADER_CLASSIFY_EN
    ,
    output logic [1:0]               a_cls,
    output logic [1:0]               b_cls
`endif
);
    localparam int NB     = OP_W / BYTE_W;
    localparam int CNT_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NB - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    loader_state_t     state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [IDLE_W-1:0] idle_r, idle_n;
    logic [OP_W-1:0]   asm_a_r, asm_b_r;
    logic [OP_W-1:0]   asm_a_s, asm_b_s;
    logic [OP_W-1:0]   op_a_r, op_b_r;
    logic              op_valid_r;
    logic              busy_r;
    logic              overrun_r;
    logic              resync_r;

    logic strobe_s, accept_s, drop_s, last_s, xfer_s, timeout_s, load_s;

    // A byte is dropped only while a second pair is parked; otherwise accepted.
    assign strobe_s = ena & bus.byte_valid;
    assign accept_s = strobe_s & (state_r != ST_HOLD_PEND);
    assign drop_s   = strobe_s & (state_r == ST_HOLD_PEND);
    assign last_s   = accept_s & (cnt_r == LAST_IDX);
    assign xfer_s   = ena & op_valid_r & bus.op_ready;

    // Assembly words with this cycle's byte merged in; also the value loaded
    // into the output slot (in HOLD_PEND nothing is accepted, so this equals
    // the parked pair).
    always_comb begin
        asm_a_s = asm_a_r;
        asm_b_s = asm_b_r;
        if (accept_s) begin
            asm_a_s[int'(cnt_r)*BYTE_W +: BYTE_W] = bus.byte_a_in;
            asm_b_s[int'(cnt_r)*BYTE_W +: BYTE_W] = bus.byte_b_in;
        end else begin
            asm_a_s = asm_a_r;
            asm_b_s = asm_b_r;
        end
    end

    // Idle counter: runs only while a partial word waits without strobes.
    always_comb begin
        idle_n    = idle_r;
        timeout_s = 1'b0;
        if (!ena) begin
            idle_n = idle_r;
        end else if (accept_s) begin
            idle_n = {IDLE_W{1'b0}};
        end else if ((TIMEOUT_CYC > 0) && (cnt_r != {CNT_W{1'b0}})) begin
            if (idle_r == IDLE_LAST) begin
                timeout_s = 1'b1;
                idle_n    = {IDLE_W{1'b0}};
            end else begin
                idle_n = idle_r + IDLE_W'(1);
            end
        end else begin
            idle_n = {IDLE_W{1'b0}};
        end
    end

    // Byte position: wraps on the last byte, cleared by the timeout.
    always_comb begin
        cnt_n = cnt_r;
        if (timeout_s || last_s) begin
            cnt_n = {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_n = cnt_r + CNT_W'(1);
        end else begin
            cnt_n = cnt_r;
        end
    end

    // Slot FSM next state; load_s marks a new pair entering op_a/op_b.
    always_comb begin
        state_n = state_r;
        load_s  = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (last_s) begin
                    state_n = ST_HOLD;
                    load_s  = 1'b1;
                end else begin
                    state_n = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (last_s && xfer_s) begin
                    state_n = ST_HOLD;
                    load_s  = 1'b1;
                end else if (last_s) begin
                    state_n = ST_HOLD_PEND;
                end else if (xfer_s) begin
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD_PEND: begin
                // Parked pair replaces the departing one with no bubble.
                if (xfer_s) begin
                    state_n = ST_HOLD;
                    load_s  = 1'b1;
                end else begin
                    state_n = ST_HOLD_PEND;
                end
            end
            default: begin
                state_n = ST_COLLECT;
            end
        endcase
    end

    // Control and status registers; ena low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_COLLECT;
            cnt_r      <= {CNT_W{1'b0}};
            idle_r     <= {IDLE_W{1'b0}};
            op_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
            resync_r   <= 1'b0;
        end else if (ena) begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            idle_r     <= idle_n;
            op_valid_r <= (state_n != ST_COLLECT);
            busy_r     <= (cnt_n != {CNT_W{1'b0}});
            overrun_r  <= overrun_r | drop_s;
            resync_r   <= timeout_s;
        end
    end

    // Assembly and output data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_a_r <= {OP_W{1'b0}};
            asm_b_r <= {OP_W{1'b0}};
            op_a_r  <= {OP_W{1'b0}};
            op_b_r  <= {OP_W{1'b0}};
        end else begin
            if (timeout_s) begin
                asm_a_r <= {OP_W{1'b0}};
                asm_b_r <= {OP_W{1'b0}};
            end else if (accept_s) begin
                asm_a_r <= asm_a_s;
                asm_b_r <= asm_b_s;
            end
            if (load_s) begin
                op_a_r <= asm_a_s;
                op_b_r <= asm_b_s;
            end
        end
    end

`ifdef AFPM_LOADER_CLASSIFY_EN
    logic [1:0] a_cls_s, b_cls_s;
    logic [1:0] a_cls_r, b_cls_r;

    afpm_fp16_classify u_cls_a (
        .value (asm_a_s[FP16_W-1:0]),
        .cls   (a_cls_s)
    );

    afpm_fp16_classify u_cls_b (
        .value (asm_b_s[FP16_W-1:0]),
        .cls   (b_cls_s)
    );

    // Class registers load together with op_a/op_b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cls_r <= CLS_ZERO;
            b_cls_r <= CLS_ZERO;
        end else if (load_s) begin
            a_cls_r <= a_cls_s;
            b_cls_r <= b_cls_s;
        end
    end

    assign a_cls = a_cls_r;
    assign b_cls = b_cls_r;
`endif

    assign bus.op_a     = op_a_r;
    assign bus.op_b     = op_b_r;
    assign bus.op_valid = op_valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;
    assign resync       = resync_r;

endmodule : afpm_operand_loader
